// File: rtl/reg_file_multiport_pkg.sv
// reg_file_multiport_pkg: shared defaults and types for the multiport register file
package reg_file_multiport_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_SEL_WIDTH = $clog2(DEF_NUM_REGS);
  typedef logic [DEF_SEL_WIDTH-1:0] reg_sel_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
  typedef struct packed {
    logic en;
    reg_sel_t sel;
    reg_data_t data;
  } write_req_t;
endpackage

// File: rtl/reg_file_write_merge.sv
// reg_file_write_merge: resolves M write ports into per-register enable/data, higher port index wins
module reg_file_write_merge
  import reg_file_multiport_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [NUM_WRITE_PORTS-1:0]            write_en,
  input  logic [NUM_WRITE_PORTS*SEL_WIDTH-1:0]  write_sel,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data,
  output logic [NUM_REGS-1:0]                   reg_we,
  output logic [DATA_WIDTH-1:0]                 reg_wd [NUM_REGS]
);
  always_comb begin
    reg_we = '0;
    for (int r = 0; r < NUM_REGS; r++) reg_wd[r] = '0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++)
      if (write_en[w] && write_sel[w*SEL_WIDTH +: SEL_WIDTH] != '0) begin
        reg_we[write_sel[w*SEL_WIDTH +: SEL_WIDTH]] = 1'b1;
        reg_wd[write_sel[w*SEL_WIDTH +: SEL_WIDTH]] = write_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
  end
endmodule

// File: rtl/reg_file_multiport.sv
// reg_file_multiport: N-read/M-write register file with bypass, zero reg and busy scoreboard; REG_FILE_DEBUG_EN adds probe ports
module reg_file_multiport
  import reg_file_multiport_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_READ_PORTS = 3,
  parameter int NUM_WRITE_PORTS = 2,
  localparam int SEL_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_READ_PORTS*SEL_WIDTH-1:0]   in_read_sel,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  out_read_data,
  output logic [NUM_READ_PORTS-1:0]             out_read_busy,
  input  logic [NUM_WRITE_PORTS-1:0]            in_write_en,
  input  logic [NUM_WRITE_PORTS*SEL_WIDTH-1:0]  in_write_sel,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] in_write_data,
  input  logic                                  in_claim_en,
  input  logic [SEL_WIDTH-1:0]                  in_claim_sel,
`ifdef REG_FILE_DEBUG_EN
  output logic [NUM_REGS*DATA_WIDTH-1:0]        out_debug_regs,
  output logic [NUM_REGS-1:0]                   out_debug_busy,
`endif
  output logic                                  out_claim_conflict
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] wd [NUM_REGS];
  logic [NUM_REGS-1:0] we, busy, busy_nxt;
  reg_file_write_merge #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS),
    .NUM_WRITE_PORTS(NUM_WRITE_PORTS), .SEL_WIDTH(SEL_WIDTH)
  ) u_merge (
    .write_en(in_write_en), .write_sel(in_write_sel), .write_data(in_write_data),
    .reg_we(we), .reg_wd(wd)
  );
  // a same-cycle claim overrides the write's release: the claimer is the new producer
  always_comb begin
    busy_nxt = '0;
    for (int r = 1; r < NUM_REGS; r++)
      busy_nxt[r] = (in_claim_en && in_claim_sel == SEL_WIDTH'(r)) || (busy[r] && !we[r]);
  end
  assign out_claim_conflict = in_claim_en && in_claim_sel != '0 && busy[in_claim_sel] && !we[in_claim_sel];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) if (we[r]) regs[r] <= wd[r];
      busy <= busy_nxt;
    end
  end
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [SEL_WIDTH-1:0] s;
    assign s = in_read_sel[p*SEL_WIDTH +: SEL_WIDTH];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_read_data[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
        out_read_busy[p] <= 1'b0;
      end else begin
        out_read_data[p*DATA_WIDTH +: DATA_WIDTH] <= we[s] ? wd[s] : regs[s];
        out_read_busy[p] <= busy_nxt[s];
      end
    end
  end
`ifdef REG_FILE_DEBUG_EN
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_dbg
    assign out_debug_regs[r*DATA_WIDTH +: DATA_WIDTH] = regs[r];
  end
  assign out_debug_busy = busy;
`endif
endmodule

// File: tb/tb_reg_file_multiport.sv
// tb_reg_file_multiport: directed and random stimulus against an array-based reference model
module tb_reg_file_multiport;
  localparam int DW = 32, NR = 16, NRP = 3, NWP = 2, SW = 4;
  logic clk = 0, rst_n = 0;
  logic [NRP*SW-1:0] in_read_sel;
  logic [NRP*DW-1:0] out_read_data;
  logic [NRP-1:0] out_read_busy;
  logic [NWP-1:0] in_write_en;
  logic [NWP*SW-1:0] in_write_sel;
  logic [NWP*DW-1:0] in_write_data;
  logic in_claim_en, out_claim_conflict;
  logic [SW-1:0] in_claim_sel;
`ifdef REG_FILE_DEBUG_EN
  logic [NR*DW-1:0] out_debug_regs;
  logic [NR-1:0] out_debug_busy;
`endif
  reg_file_multiport dut (
    .clk(clk), .rst_n(rst_n), .in_read_sel(in_read_sel), .out_read_data(out_read_data),
    .out_read_busy(out_read_busy), .in_write_en(in_write_en), .in_write_sel(in_write_sel),
    .in_write_data(in_write_data), .in_claim_en(in_claim_en), .in_claim_sel(in_claim_sel),
`ifdef REG_FILE_DEBUG_EN
    .out_debug_regs(out_debug_regs), .out_debug_busy(out_debug_busy),
`endif
    .out_claim_conflict(out_claim_conflict)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [DW-1:0] m_regs [NR];
  logic m_busy [NR];
  logic [SW-1:0] rs [NRP];
  logic wen [NWP];
  logic [SW-1:0] ws [NWP];
  logic [DW-1:0] wdat [NWP];
  logic cen;
  logic [SW-1:0] cs;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    for (int p = 0; p < NRP; p++) rs[p] = '0;
    for (int w = 0; w < NWP; w++) begin wen[w] = 0; ws[w] = '0; wdat[w] = '0; end
    cen = 0; cs = '0;
  endtask
  // drive one cycle, predict from the model, clock, then compare
  task automatic step();
    logic [DW-1:0] n_regs [NR];
    logic n_busy [NR];
    logic hit;
    for (int p = 0; p < NRP; p++) in_read_sel[p*SW +: SW] = rs[p];
    for (int w = 0; w < NWP; w++) begin
      in_write_en[w] = wen[w]; in_write_sel[w*SW +: SW] = ws[w]; in_write_data[w*DW +: DW] = wdat[w];
    end
    in_claim_en = cen; in_claim_sel = cs;
    hit = 0;
    for (int w = 0; w < NWP; w++) if (wen[w] && ws[w] == cs) hit = 1;
    #1 chk("conflict", DW'(out_claim_conflict), DW'(cen && cs != 0 && m_busy[cs] && !hit));
    for (int r = 0; r < NR; r++) begin n_regs[r] = m_regs[r]; n_busy[r] = m_busy[r]; end
    if (!rst_n) for (int r = 0; r < NR; r++) begin n_regs[r] = '0; n_busy[r] = 0; end
    else begin
      for (int w = 0; w < NWP; w++) if (wen[w] && ws[w] != 0) begin n_regs[ws[w]] = wdat[w]; n_busy[ws[w]] = 0; end
      if (cen && cs != 0) n_busy[cs] = 1;
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin m_regs[r] = n_regs[r]; m_busy[r] = n_busy[r]; end
    for (int p = 0; p < NRP; p++) begin
      chk($sformatf("rd_data p%0d r%0d", p, rs[p]), out_read_data[p*DW +: DW], m_regs[rs[p]]);
      chk($sformatf("rd_busy p%0d r%0d", p, rs[p]), DW'(out_read_busy[p]), DW'(m_busy[rs[p]]));
    end
`ifdef REG_FILE_DEBUG_EN
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("dbg_reg r%0d", r), out_debug_regs[r*DW +: DW], m_regs[r]);
      chk($sformatf("dbg_busy r%0d", r), DW'(out_debug_busy[r]), DW'(m_busy[r]));
    end
`endif
    #3;
  endtask
  initial begin
    for (int r = 0; r < NR; r++) begin m_regs[r] = 'x; m_busy[r] = 1'bx; end
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    for (int r = 0; r < NR; r += 2) begin
      idle(); wen[0] = 1; ws[0] = SW'(r); wdat[0] = 32'h1000 + r;
      wen[1] = 1; ws[1] = SW'(r + 1); wdat[1] = 32'h2000 + r;
      cen = 1; cs = SW'(r + 1); rs[0] = SW'(r); rs[1] = SW'(r + 1);
      step();
    end
    idle(); rst_n = 0; step(); rst_n = 1;
    for (int r = 0; r < NR; r += 3) begin
      idle(); rs[0] = SW'(r); rs[1] = SW'((r + 1) % NR); rs[2] = SW'((r + 2) % NR); step();
    end
    idle(); wen[0] = 1; ws[0] = 0; wdat[0] = 32'hDEADBEEF; rs[0] = 0; step();
    idle(); cen = 1; cs = 0; rs[0] = 0; step();
    idle(); cen = 1; cs = 0; rs[0] = 0; step();
    idle(); wen[1] = 1; ws[1] = 5; wdat[1] = 32'h1234; rs[0] = 5; step();
    idle(); rs[2] = 5; step();
    idle(); wen[0] = 1; ws[0] = 3; wdat[0] = 32'hAAAA; wen[1] = 1; ws[1] = 3; wdat[1] = 32'hBBBB; rs[1] = 3; step();
    idle(); rs[0] = 3; step();
    idle(); cen = 1; cs = 7; rs[0] = 7; step();
    idle(); cen = 1; cs = 7; rs[0] = 7; step();
    idle(); wen[0] = 1; ws[0] = 7; wdat[0] = 32'h77; rs[0] = 7; step();
    idle(); cen = 1; cs = 7; wen[1] = 1; ws[1] = 7; wdat[1] = 32'h78; rs[0] = 7; step();
    idle(); cen = 1; cs = 7; wen[0] = 1; ws[0] = 7; wdat[0] = 32'h79; rs[1] = 7; step();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int p = 0; p < NRP; p++) rs[p] = SW'($urandom_range(0, NR - 1));
      for (int w = 0; w < NWP; w++) begin
        wen[w] = $urandom_range(0, 1) == 1; ws[w] = SW'($urandom_range(0, 7)); wdat[w] = $urandom;
      end
      cen = $urandom_range(0, 1) == 1; cs = SW'($urandom_range(0, 7));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
